cache_way_array: RTL and testbench

- Parametrised set-associative cache storage engine, successor to the plain way-memory wrapper in the instruction/data cache path.
- Adds parallel tag compare with hit/way resolution and per-set victim selection (invalid-first, then round-robin).
- Adds read-modify-write line fill, and single-set and whole-cache invalidate sequencing.
- Sits between the cache controller FSM and the backing memory interface; the controller only issues ops and consumes responses.

---
 rtl/cache_way_array.sv | 239 +++++++++++++++++++++++
 tb/tb_cache_way_array.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_array.sv
// Set-associative tag/line storage with parallel tag compare, invalid-first then
// round-robin victim choice, byte-merged line fill and set/whole-cache invalidate.
module cache_way_array #(
   parameter int unsigned WAY_COUNT      = 2,
   parameter int unsigned SET_COUNT      = 64,
   parameter int unsigned WAY_WORD_COUNT = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [1:0]                   req_op_i,
   input  logic [31:0]                  req_addr_i,
   input  logic [32*WAY_WORD_COUNT-1:0] fill_line_i,
   input  logic [4*WAY_WORD_COUNT-1:0]  fill_be_i,
   output logic                         rsp_valid_o,
   output logic                         rsp_hit_o,
   output logic [$clog2(WAY_COUNT)-1:0] rsp_way_o,
   output logic [32*WAY_WORD_COUNT-1:0] rsp_line_o,
   output logic                         busy_o
);

   localparam int unsigned WW_W   = $clog2(WAY_WORD_COUNT);
   localparam int unsigned SET_W  = $clog2(SET_COUNT);
   localparam int unsigned WAY_W  = $clog2(WAY_COUNT);
   localparam int unsigned TAG_W  = 30 - WW_W - SET_W;
   localparam int unsigned LINE_W = 32 * WAY_WORD_COUNT;
   localparam int unsigned BE_W   = 4 * WAY_WORD_COUNT;
   localparam int unsigned CNT_W  = SET_W + 1;

   localparam logic [1:0] OP_LOOKUP  = 2'b00;
   localparam logic [1:0] OP_INV_SET = 2'b10;
   localparam logic [1:0] OP_INV_ALL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RESP,
      ST_WRITE,
      ST_FLUSH
   } state_e;

   state_e                state_q;
   logic [1:0]            op_q;
   logic [SET_W-1:0]      set_q;
   logic [TAG_W-1:0]      tag_q;
   logic [LINE_W-1:0]     line_q;
   logic [BE_W-1:0]       be_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [WAY_W-1:0]      tgt_q;
   logic                  hit_q;
   logic                  adv_q;
   logic [LINE_W-1:0]     merged_q;
   logic [WAY_COUNT-1:0]  valid_q [SET_COUNT];
   logic [WAY_W-1:0]      rr_q [SET_COUNT];
   logic                  rsp_valid_q;
   logic                  rsp_hit_q;
   logic [WAY_W-1:0]      rsp_way_q;
   logic [LINE_W-1:0]     rsp_line_q;
   logic                  busy_q;

   logic [SET_W-1:0]      req_set_c;
   logic [TAG_W-1:0]      req_tag_c;
   logic                  rd_en_c;
   logic                  wr_en_c;
   logic [TAG_W-1:0]      tag_rd_c [WAY_COUNT];
   logic [LINE_W-1:0]     data_rd_c [WAY_COUNT];
   logic [WAY_COUNT-1:0]  valid_set_c;
   logic [WAY_COUNT-1:0]  match_c;
   logic [WAY_COUNT-1:0]  inv_c;
   logic                  hit_c;
   logic [WAY_W-1:0]      hit_way_c;
   logic [WAY_W-1:0]      inv_way_c;
   logic [WAY_W-1:0]      tgt_c;
   logic [LINE_W-1:0]     old_line_c;
   logic [LINE_W-1:0]     merged_c;
   logic                  unused_addr_c;

   assign req_set_c     = req_addr_i[WW_W+2 +: SET_W];
   assign req_tag_c     = req_addr_i[WW_W+SET_W+2 +: TAG_W];
   assign unused_addr_c = ^req_addr_i[WW_W+1:0];

   assign req_ready_o = (state_q == ST_IDLE) && !reset;
   assign rd_en_c     = req_ready_o && req_valid_i && !req_op_i[1];
   assign wr_en_c     = (state_q == ST_WRITE);

   // Per-way tag and line arrays with synchronous read; not reset.
   for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
      logic [TAG_W-1:0]  tag_mem [SET_COUNT];
      logic [LINE_W-1:0] data_mem [SET_COUNT];
      logic [TAG_W-1:0]  tag_rd_q;
      logic [LINE_W-1:0] data_rd_q;

      always_ff @(posedge clk) begin
         if (rd_en_c) begin
            tag_rd_q  <= tag_mem[req_set_c];
            data_rd_q <= data_mem[req_set_c];
         end
         if (wr_en_c && (tgt_q == WAY_W'(w))) begin
            tag_mem[set_q]  <= tag_q;
            data_mem[set_q] <= merged_q;
         end
      end

      assign tag_rd_c[w]  = tag_rd_q;
      assign data_rd_c[w] = data_rd_q;
      assign match_c[w]   = valid_set_c[w] && (tag_rd_q == tag_q);
   end

   assign valid_set_c = valid_q[set_q];
   assign inv_c       = ~valid_set_c;
   assign hit_c       = |match_c;

   // Lowest-index hit and lowest-index invalid way; victim falls back to rr pointer.
   always_comb begin
      hit_way_c = '0;
      inv_way_c = '0;
      for (int w = WAY_COUNT - 1; w >= 0; w--) begin
         if (match_c[WAY_W'(w)]) hit_way_c = WAY_W'(w);
         if (inv_c[WAY_W'(w)])   inv_way_c = WAY_W'(w);
      end
      if (hit_c)       tgt_c = hit_way_c;
      else if (|inv_c) tgt_c = inv_way_c;
      else             tgt_c = rr_q[set_q];
      old_line_c = data_rd_c[tgt_c];
   end

   for (genvar b = 0; b < BE_W; b++) begin : g_byte
      assign merged_c[8*b +: 8] = be_q[b] ? line_q[8*b +: 8] : old_line_c[8*b +: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LOOKUP;
         set_q       <= '0;
         tag_q       <= '0;
         line_q      <= '0;
         be_q        <= '0;
         cnt_q       <= '0;
         tgt_q       <= '0;
         hit_q       <= 1'b0;
         adv_q       <= 1'b0;
         merged_q    <= '0;
         valid_q     <= '{default: '0};
         rr_q        <= '{default: '0};
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_way_q   <= '0;
         rsp_line_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  op_q   <= req_op_i;
                  set_q  <= req_set_c;
                  tag_q  <= req_tag_c;
                  line_q <= fill_line_i;
                  be_q   <= fill_be_i;
                  busy_q <= 1'b1;
                  case (req_op_i)
                     OP_INV_SET: begin
                        valid_q[req_set_c] <= '0;
                        rr_q[req_set_c]    <= '0;
                        rsp_hit_q          <= 1'b0;
                        rsp_way_q          <= '0;
                        rsp_line_q         <= '0;
                        rsp_valid_q        <= 1'b1;
                        state_q            <= ST_RESP;
                     end
                     OP_INV_ALL: begin
                        cnt_q   <= '0;
                        state_q <= ST_FLUSH;
                     end
                     default: state_q <= ST_READ;
                  endcase
               end
            end
            ST_READ: begin
               if (op_q == OP_LOOKUP) begin
                  rsp_hit_q   <= hit_c;
                  rsp_way_q   <= hit_way_c;
                  rsp_line_q  <= hit_c ? data_rd_c[hit_way_c] : '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  hit_q    <= hit_c;
                  tgt_q    <= tgt_c;
                  merged_q <= merged_c;
                  adv_q    <= !hit_c && !(|inv_c);
                  state_q  <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               valid_q[set_q][tgt_q] <= 1'b1;
               // Victim pointer only moves when a full set had to evict.
               if (adv_q) begin
                  rr_q[set_q] <= (rr_q[set_q] == WAY_W'(WAY_COUNT - 1)) ? '0
                                                                        : rr_q[set_q] + 1'b1;
               end
               rsp_hit_q   <= hit_q;
               rsp_way_q   <= tgt_q;
               rsp_line_q  <= merged_q;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_FLUSH: begin
               valid_q[cnt_q[SET_W-1:0]] <= '0;
               rr_q[cnt_q[SET_W-1:0]]    <= '0;
               cnt_q                     <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(SET_COUNT - 1)) begin
                  rsp_hit_q   <= 1'b0;
                  rsp_way_q   <= '0;
                  rsp_line_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_RESP: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_hit_o   = rsp_hit_q;
   assign rsp_way_o   = rsp_way_q;
   assign rsp_line_o  = rsp_line_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_cache_way_array.sv
// Randomized bench for cache_way_array against a per-set/per-way array model
// of the cache contents, victim choice and response timing.
module tb_cache_way_array;

   localparam int WAYS   = 2;
   localparam int SETS   = 64;
   localparam int LINE_W = 128;
   localparam int BE_W   = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [31:0]       req_addr;
   logic [LINE_W-1:0] fill_line;
   logic [BE_W-1:0]   fill_be;
   logic              rsp_valid;
   logic              rsp_hit;
   logic [0:0]        rsp_way;
   logic [LINE_W-1:0] rsp_line;
   logic              busy;

   cache_way_array dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_addr_i  (req_addr),
      .fill_line_i (fill_line),
      .fill_be_i   (fill_be),
      .rsp_valid_o (rsp_valid),
      .rsp_hit_o   (rsp_hit),
      .rsp_way_o   (rsp_way),
      .rsp_line_o  (rsp_line),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference cache: contents per set/way, victim pointer per set.
   bit                m_valid [SETS][WAYS];
   logic [21:0]       m_tag   [SETS][WAYS];
   logic [LINE_W-1:0] m_line  [SETS][WAYS];
   int                m_rr    [SETS];
   logic              e_hit;
   int                e_way;
   logic [LINE_W-1:0] e_line;

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void m_clear_all();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
   endfunction

   function automatic int m_find(input logic [31:0] addr);
      int s;
      s = int'(addr[9:4]);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == addr[31:10]) return w;
      return -1;
   endfunction

   function automatic void model_op(input logic [1:0] op, input logic [31:0] addr,
                                    input logic [LINE_W-1:0] line, input logic [BE_W-1:0] be);
      int s, hw, iw, tgt;
      logic [LINE_W-1:0] merged;
      s  = int'(addr[9:4]);
      hw = m_find(addr);
      iw = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) iw = w;
      e_hit  = 1'b0;
      e_way  = 0;
      e_line = '0;
      case (op)
         2'b00: if (hw >= 0) begin
            e_hit  = 1'b1;
            e_way  = hw;
            e_line = m_line[s][hw];
         end
         2'b01: begin
            if (hw >= 0)      tgt = hw;
            else if (iw >= 0) tgt = iw;
            else begin
               tgt     = m_rr[s];
               m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            merged = m_line[s][tgt];
            for (int b = 0; b < BE_W; b++) if (be[b]) merged[8*b +: 8] = line[8*b +: 8];
            m_valid[s][tgt] = 1'b1;
            m_tag[s][tgt]   = addr[31:10];
            m_line[s][tgt]  = merged;
            e_hit  = (hw >= 0);
            e_way  = tgt;
            e_line = merged;
         end
         2'b10: begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
         end
         default: m_clear_all();
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] op);
      case (op)
         2'b00:   return 2;
         2'b01:   return 3;
         2'b10:   return 1;
         default: return SETS + 1;
      endcase
   endfunction

   // One request: issue, then watch response timing, busy window and payload.
   task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input logic [LINE_W-1:0] line,
                         input logic [BE_W-1:0] be, output int way_got);
      int n, nv, lat, nbusy;
      logic              h;
      logic [0:0]        w;
      logic [LINE_W-1:0] l;
      string             nm;
      nm = (op == 2'b00) ? "lookup" : (op == 2'b01) ? "fill" : (op == 2'b10) ? "inv_set" : "inv_all";
      @(negedge clk);
      chk({nm, ".ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      fill_line = line;
      fill_be   = be;
      model_op(op, addr, line, be);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      fill_line = {$urandom, $urandom, $urandom, $urandom};
      fill_be   = 16'($urandom);
      n = 0; nv = 0; lat = 0; nbusy = 0;
      h = 1'b0; w = '0; l = '0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (rsp_valid) begin
            nv++;
            lat = n;
            h = rsp_hit;
            w = rsp_way;
            l = rsp_line;
         end
         if (!busy) break;
         nbusy++;
      end
      chk({nm, ".idle_at_end"}, busy, 0);
      chk({nm, ".latency"}, lat, lat_of(op));
      chk({nm, ".pulses"}, nv, 1);
      chk({nm, ".busy_cycles"}, nbusy, lat_of(op));
      if (op != 2'b11) begin
         chk({nm, ".hit"}, h, e_hit);
         chk({nm, ".way"}, w, e_way);
         chk({nm, ".line"}, l, e_line);
         chk({nm, ".hold_line"}, rsp_line, e_line);
      end
      way_got = int'(w);
   endtask

   localparam logic [LINE_W-1:0] LINE_A = 128'h44444444_33333333_22222222_11111111;

   initial begin
      int wg, pulses, r;
      logic [31:0]       a;
      logic [LINE_W-1:0] d;
      logic [BE_W-1:0]   be;

      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; fill_line = '0; fill_be = '0;
      m_clear_all();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.ready_low", req_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("reset.ready", req_ready, 1);
      chk("reset.busy", busy, 0);
      chk("reset.rsp_valid", rsp_valid, 0);
      chk("reset.rsp_hit", rsp_hit, 0);
      chk("reset.rsp_way", rsp_way, 0);
      chk("reset.rsp_line", rsp_line, 0);

      run_op(2'b00, 32'h100, '0, '0, wg);
      run_op(2'b01, 32'h100, LINE_A, 16'hFFFF, wg);
      chk("dir.fill100_way", wg, 0);
      run_op(2'b00, 32'h104, '0, '0, wg);
      chk("dir.hit_line", rsp_line, LINE_A);

      run_op(2'b01, 32'h000, {4{32'hA0A0A0A0}}, 16'hFFFF, wg);
      chk("dir.fill000_way", wg, 0);
      run_op(2'b01, 32'h400, {4{32'hB1B1B1B1}}, 16'hFFFF, wg);
      chk("dir.fill400_way", wg, 1);
      run_op(2'b01, 32'h800, {4{32'hC2C2C2C2}}, 16'hFFFF, wg);
      chk("dir.fill800_way", wg, 0);
      run_op(2'b00, 32'h000, '0, '0, wg);
      chk("dir.miss000", rsp_hit, 0);
      run_op(2'b00, 32'h400, '0, '0, wg);
      chk("dir.hit400_way", wg, 1);

      run_op(2'b01, 32'h400, {96'h0, 32'hDEADBEEF}, 16'h000F, wg);
      chk("dir.partial_line", rsp_line, {{3{32'hB1B1B1B1}}, 32'hDEADBEEF});
      run_op(2'b01, 32'hC00, {4{32'hD3D3D3D3}}, 16'hFFFF, wg);
      chk("dir.rr_kept_way", wg, 1);

      run_op(2'b11, 32'h0, '0, '0, wg);
      run_op(2'b00, 32'h100, '0, '0, wg);
      run_op(2'b00, 32'hC00, '0, '0, wg);
      run_op(2'b01, 32'h400, {4{32'hE4E4E4E4}}, 16'hFFFF, wg);
      chk("dir.after_flush_way", wg, 0);

      // Random mix over a few sets and tags to force hits, evictions and invalidates.
      for (int i = 0; i < 250; i++) begin
         r = int'($urandom_range(0, 99));
         a = {20'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 3)), 2'($urandom), 2'b00};
         d = {$urandom, $urandom, $urandom, $urandom};
         be = (m_find(a) >= 0) ? 16'($urandom) : 16'hFFFF;
         if (r < 45)      run_op(2'b00, a, '0, '0, wg);
         else if (r < 85) run_op(2'b01, a, d, be, wg);
         else if (r < 96) run_op(2'b10, a, '0, '0, wg);
         else             run_op(2'b11, a, '0, '0, wg);
      end

      // Reset ten cycles into a whole-cache invalidate.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 2'b11;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      reset = 1'b1;
      #1;
      chk("abort.busy_in_reset", busy, 0);
      m_clear_all();
      @(negedge clk);
      if (rsp_valid) pulses++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort.ready", req_ready, 1);
      chk("abort.busy", busy, 0);
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      chk("abort.pulses", pulses, 0);
      run_op(2'b00, 32'h400, '0, '0, wg);
      run_op(2'b01, 32'h800, {4{32'hF5F5F5F5}}, 16'hFFFF, wg);
      chk("abort.fill_way", wg, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
